// File: rtl/seg_display_scheduler_if.sv
// Requester-side bundle for the display scheduler: three BCD sources in,
// current owner, displayed word and dwell status out.
interface seg_display_scheduler_if;
  logic [2:0]  req;
  logic [15:0] data0;
  logic [15:0] data1;
  logic [15:0] data2;
  logic [2:0]  grant;
  logic [15:0] nums;
  logic        dwell_done;

  modport master (
    output req, data0, data1, data2,
    input  grant, nums, dwell_done
  );

  modport slave (
    input  req, data0, data1, data2,
    output grant, nums, dwell_done
  );
endinterface

// File: rtl/seg_display_scheduler.sv
// Round-robin time-sharing of one four-digit seven-segment display among
// three requesters, with a minimum dwell per grant and an idle pattern.
module seg_display_scheduler #(
  parameter int          HOLD_CYCLES = 50_000_000,
  parameter logic [15:0] IDLE_NUMS   = 16'hFFFF
) (
  input logic                     clk,
  input logic                     rst,
  seg_display_scheduler_if.slave  bus
);

  localparam int TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [TW-1:0] TMAX = TW'(HOLD_CYCLES - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_OWN  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [1:0]    owner_q, owner_d;
  logic [1:0]    last_q, last_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [15:0]   nums_q, nums_d;

  function automatic logic [1:0] next_idx(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] x);
    logic [2:0] oh;
    oh = 3'b000;
    case (x)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  // Winner of a request vector, searching from last+1 and visiting last at the end.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
    logic [3:0] rr;
    logic [1:0] c0, c1, c2, idx;
    rr  = {1'b0, r};
    c0  = next_idx(last);
    c1  = next_idx(c0);
    c2  = next_idx(c1);
    idx = c2;
    if (rr[c1]) idx = c1;
    if (rr[c0]) idx = c0;
    return idx;
  endfunction

  function automatic logic [15:0] sel_data(input logic [1:0] idx, input logic [15:0] d0,
                                           input logic [15:0] d1, input logic [15:0] d2);
    logic [15:0] d;
    case (idx)
      2'd0:    d = d0;
      2'd1:    d = d1;
      default: d = d2;
    endcase
    return d;
  endfunction

  logic       own_req;
  logic [2:0] others;
  logic       done;
  logic [1:0] pick_idle, pick_hand;

  always_comb begin
    own_req   = |(bus.req & onehot(owner_q));
    others    = bus.req & ~onehot(owner_q);
    done      = (timer_q == TMAX);
    pick_idle = rr_pick(bus.req, last_q);
    pick_hand = rr_pick(others, owner_q);

    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    timer_d = timer_q;
    nums_d  = nums_q;

    if (state_q == S_IDLE) begin
      nums_d  = IDLE_NUMS;
      timer_d = '0;
      if (|bus.req) begin
        state_d = S_OWN;
        owner_d = pick_idle;
        last_d  = pick_idle;
        nums_d  = sel_data(pick_idle, bus.data0, bus.data1, bus.data2);
      end
    end else if (!done) begin
      // Grant is held regardless of req until the dwell elapses; data freezes if req drops.
      timer_d = timer_q + TW'(1);
      if (own_req) nums_d = sel_data(owner_q, bus.data0, bus.data1, bus.data2);
    end else if (|others) begin
      owner_d = pick_hand;
      last_d  = pick_hand;
      timer_d = '0;
      nums_d  = sel_data(pick_hand, bus.data0, bus.data1, bus.data2);
    end else if (own_req) begin
      nums_d = sel_data(owner_q, bus.data0, bus.data1, bus.data2);
    end else begin
      state_d = S_IDLE;
      timer_d = '0;
      nums_d  = IDLE_NUMS;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= 2'd0;
      last_q  <= 2'd2;
      timer_q <= '0;
      nums_q  <= IDLE_NUMS;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      timer_q <= timer_d;
      nums_q  <= nums_d;
    end
  end

  assign bus.grant      = (state_q == S_OWN) ? onehot(owner_q) : 3'b000;
  assign bus.nums       = nums_q;
  assign bus.dwell_done = (state_q == S_OWN) && (timer_q == TMAX);

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Directed bench for seg_display_scheduler with HOLD_CYCLES=4, IDLE_NUMS=16'hFFFF.
module tb_seg_display_scheduler;
  logic clk;
  logic rst;
  int   errs;
  int   checks;

  seg_display_scheduler_if bus();

  seg_display_scheduler #(.HOLD_CYCLES(4), .IDLE_NUMS(16'hFFFF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [2:0] g, input logic [15:0] n,
                           input logic d);
    check({tag, ".grant"}, 32'(bus.grant), 32'(g));
    check({tag, ".nums"},  32'(bus.nums),  32'(n));
    check({tag, ".dwell"}, 32'(bus.dwell_done), 32'(d));
  endtask

  logic [2:0]  exp_g [4];
  logic [15:0] exp_n [4];

  initial begin
    errs = 0;
    checks = 0;
    rst = 1'b1;
    bus.req = 3'b111;
    bus.data0 = 16'h1111;
    bus.data1 = 16'h2222;
    bus.data2 = 16'h3333;

    // Reset with all requests pending
    step();
    check_out("rst0", 3'b000, 16'hFFFF, 1'b0);
    step();
    check_out("rst1", 3'b000, 16'hFFFF, 1'b0);
    rst = 1'b0;
    step();

    // Round-robin handover, 4 cycles per owner, no gaps
    exp_g[0] = 3'b001; exp_n[0] = 16'h1111;
    exp_g[1] = 3'b010; exp_n[1] = 16'h2222;
    exp_g[2] = 3'b100; exp_n[2] = 16'h3333;
    exp_g[3] = 3'b001; exp_n[3] = 16'h1111;
    for (int o = 0; o < 4; o++) begin
      for (int c = 0; c < 4; c++) begin
        check_out($sformatf("rr%0d_c%0d", o, c), exp_g[o], exp_n[o], c == 3);
        step();
      end
    end

    // Clean restart
    bus.req = 3'b000;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check_out("idle", 3'b000, 16'hFFFF, 1'b0);

    // Single requester, live data
    bus.req = 3'b010;
    bus.data1 = 16'h1234;
    step();
    for (int c = 0; c < 6; c++) begin
      check_out($sformatf("live_c%0d", c), 3'b010, 16'h1234, c >= 3);
      if (c == 5) bus.data1 = 16'h0039;
      step();
    end
    check_out("live_c6", 3'b010, 16'h0039, 1'b1);
    bus.req = 3'b000;
    step();
    check_out("live_end", 3'b000, 16'hFFFF, 1'b0);

    // Early release freezes the word and holds the grant for the full dwell
    bus.req = 3'b100;
    bus.data2 = 16'h0007;
    step();
    check_out("frz_c0", 3'b100, 16'h0007, 1'b0);
    bus.req = 3'b000;
    bus.data2 = 16'h0008;
    for (int c = 1; c < 4; c++) begin
      step();
      check_out($sformatf("frz_c%0d", c), 3'b100, 16'h0007, c == 3);
    end
    step();
    check_out("frz_end", 3'b000, 16'hFFFF, 1'b0);

    // Owner retained past dwell, then handover to a late requester
    bus.req = 3'b001;
    bus.data0 = 16'h00AB;
    bus.data1 = 16'h4567;
    step();
    for (int c = 0; c < 9; c++) begin
      check_out($sformatf("ret_c%0d", c), 3'b001, 16'h00AB, c >= 3);
      if (c == 8) bus.req = 3'b011;
      step();
    end
    check_out("ret_hand", 3'b010, 16'h4567, 1'b0);

    // Mid-grant reset, then restart from requester 0
    step();
    step();
    check_out("mid_c2", 3'b010, 16'h4567, 1'b0);
    rst = 1'b1;
    step();
    check_out("mid_rst", 3'b000, 16'hFFFF, 1'b0);
    rst = 1'b0;
    step();
    check_out("mid_rel0", 3'b001, 16'h00AB, 1'b0);

    // Reset again with only requester 1 pending
    bus.req = 3'b010;
    rst = 1'b1;
    step();
    check_out("mid_rst2", 3'b000, 16'hFFFF, 1'b0);
    rst = 1'b0;
    step();
    check_out("mid_rel1", 3'b010, 16'h4567, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/seg_display_scheduler.md
# seg_display_scheduler

Time-shares the single four-digit seven-segment display between three requesters: the game-state readout, the score readout and the alert/message source. Each requester presents a 16-bit packed BCD word, four digits of 4 bits each. The block grants the display round-robin and enforces a minimum dwell per grant. It drives the registered 16-bit `nums` word into the seven-segment driver. When no requester is active, it shows a configurable idle pattern.

## Interface
- `HOLD_CYCLES`, default 50_000_000: minimum dwell of one grant, in `clk` cycles. Must be ≥ 1.
- `IDLE_NUMS`, default 16'hFFFF: word shown when no grant is active. Nibbles > 9 render as a dash.
- `clk` input 1: system clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req` input 3: request per source. Bit i is requester i.
- `data0` input 16: display word of requester 0.
- `data1` input 16: display word of requester 1.
- `data2` input 16: display word of requester 2.
- `grant` output 3: one-hot current owner. 3'b000 when idle.
- `nums` output 16: word to the seven-segment driver, registered.
- `dwell_done` output 1: high while the current owner's minimum dwell has elapsed.

## Operation
- Clock and reset:
  - One clock; reset is synchronous and active-high.
  - All state updates on rising `clk`. `rst` sampled only at the edge.
- States:
  - IDLE: no owner.
  - OWN: one owner, dwell timer running or saturated.
- IDLE:
  - `grant`=0, `nums`=`IDLE_NUMS`, timer=0.
  - If any `req` bit is high, pick the winner by round-robin and go to OWN.
- Round-robin:
  - Search order starts at `(last_owner+1) mod 3` and wraps.
  - After reset, `last_owner`=2, so requester 0 has highest priority first.
  - `last_owner` updates on every new grant.
- OWN, timer:
  - Timer counts 0 → `HOLD_CYCLES-1`, then saturates.
  - `dwell_done`=1 when timer = `HOLD_CYCLES-1`.
- OWN, live data:
  - While the owner's `req` is high, `nums` loads the owner's `dataN` every cycle.
- OWN, owner drops `req` before dwell done:
  - `nums` freezes at the last loaded word.
  - The grant is held until dwell is done.
- OWN, dwell done, re-arbitrate in the same cycle:
  - If any non-owner `req` is high: grant the next requester in round-robin order, with the current owner searched last. Reload the timer to 0 and load the new owner's data.
  - Else if the owner's `req` is high: keep the grant, timer stays saturated, data stays live.
  - Else: go to IDLE (`grant`=0, `nums`=`IDLE_NUMS`).
- Invariants:
  - `grant` is always one-hot or zero.
  - A requester never loses the display before `HOLD_CYCLES` cycles of ownership.
- Timer width is `$clog2(HOLD_CYCLES)`, minimum 1 bit. No overflow: the timer saturates.

## Timing
- Reset values: `grant`=3'b000, `nums`=`IDLE_NUMS`, `dwell_done`=0, timer=0, `last_owner`=2, state IDLE.
- `rst` high mid-grant: on the next edge all outputs take their reset values. Requests pending at that edge are ignored.
- Grant latency from IDLE: `req` sampled high at edge k gives `grant` and owner data on `nums` after edge k.
- Data latency while owner is live: a `dataN` change sampled at edge k appears on `nums` after edge k.
- Dwell length: the first owned cycle has timer 0, so `dwell_done` rises `HOLD_CYCLES-1` edges after the grant.
  - With `HOLD_CYCLES`=1, `dwell_done` is high in the first owned cycle.
- Handover: at the edge where `dwell_done`=1 and another `req` is high, `grant` switches with no idle gap. `nums` shows the new owner's data in the same cycle.
- Simultaneous requests in IDLE: the round-robin order resolves them. The losers stay pending and are not dropped.
- `req` pulses shorter than one cycle are missed. Requesters hold `req` until they see their `grant` bit.
- `dataN` of non-owners is ignored.

## Test plan
Run all scenarios with `HOLD_CYCLES`=4 and `IDLE_NUMS`=16'hFFFF.
- Reset:
  - Stimulus: `rst` high 2 cycles, `req`=3'b111, then `rst` low.
  - Required: `grant`=0 and `nums`=16'hFFFF during reset. `grant`=3'b001 and `nums`=`data0` one edge after `rst` falls.
- Single requester, live data:
  - Stimulus: `req`=3'b010 held, `data1`=16'h1234, changed to 16'h0039 at cycle 6.
  - Required: `grant`=3'b010 from the first edge. `dwell_done`=1 from the 4th owned cycle. `nums`=16'h0039 one edge after the change.
- Round-robin handover:
  - Stimulus: `req`=3'b111 held, distinct `data0`..`data2`.
  - Required: `grant` sequence 001, 010, 100, 001, each held exactly 4 cycles. `nums` switches in the same cycle as `grant`.
- Early release and freeze:
  - Stimulus: requester 2 granted with `data2`=16'h0007, `req` dropped at owned cycle 1, `data2` changed to 16'h0008.
  - Required: `nums` stays 16'h0007 through owned cycle 3. Then `grant`=0 and `nums`=16'hFFFF.
- Owner retained:
  - Stimulus: `req`=3'b001 held for 10 cycles.
  - Required: `grant` stays 001 and `dwell_done` stays 1 from cycle 3 on. `req[1]` raised at cycle 8 gives `grant`=010 after the next edge.
- Mid-grant reset:
  - Stimulus: `rst` pulsed at owned cycle 2 of requester 1, with `req` held high.
  - Required: next cycle `grant`=0, `nums`=16'hFFFF, `dwell_done`=0. After release, `grant`=001 if `req[0]` is high, otherwise `grant`=010.
